// File: rtl/la_csaacc.sv
// la_csaacc: carry-save multi-operand accumulator; 4:2 compression per beat,
// one carry-propagate add per packet, result returned over valid/ready.
module la_csaacc #(
  parameter int    N      = 32,
  parameter int    G      = 4,
  parameter bit    SIGNED = 1'b0,
  parameter string PROP   = "DEFAULT"
) (
  input  logic           clk,
  input  logic           nreset,
  input  logic           clear,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   in_a,
  input  logic [N-1:0]   in_b,
  input  logic           in_last,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N+G-1:0] out_data,
  output logic           out_ovf
);
  localparam int W = N + G;
  typedef enum logic [1:0] {ACC, RES, OUT} state_e;
  state_e       state_q, state_d;
  logic [W-1:0] acc_s_q, acc_s_d, acc_c_q, acc_c_d, data_q, data_d;
  logic [W-1:0] ext_a, ext_b, s1, k1, s2, k2;
  logic [G:0]   cnt_q, cnt_d;
  logic         ovf_q, ovf_d, accept;
  assign ext_a = SIGNED ? {{G{in_a[N-1]}}, in_a} : {{G{1'b0}}, in_a};
  assign ext_b = SIGNED ? {{G{in_b[N-1]}}, in_b} : {{G{1'b0}}, in_b};
  // two 3:2 rows; the left shifts discard the carry out of bit W-1
  assign s1 = acc_s_q ^ acc_c_q ^ ext_a;
  assign k1 = ((acc_s_q & acc_c_q) | (acc_s_q & ext_a) | (acc_c_q & ext_a)) << 1;
  assign s2 = s1 ^ k1 ^ ext_b;
  assign k2 = ((s1 & k1) | (s1 & ext_b) | (k1 & ext_b)) << 1;
  assign in_ready  = state_q == ACC;
  assign out_valid = state_q == OUT;
  assign out_data  = data_q;
  assign out_ovf   = ovf_q;
  assign accept    = in_valid & in_ready;
  always_comb begin
    state_d = state_q;
    acc_s_d = acc_s_q;
    acc_c_d = acc_c_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    ovf_d   = ovf_q;
    if (clear) begin
      state_d = ACC;
      acc_s_d = '0;
      acc_c_d = '0;
      cnt_d   = '0;
    end else if (state_q == ACC) begin
      if (accept) begin
        acc_s_d = s2;
        acc_c_d = k2;
        cnt_d   = cnt_q + {{G{1'b0}}, ~&cnt_q};
        state_d = in_last ? RES : ACC;
      end
    end else if (state_q == RES) begin
      data_d  = acc_s_q + acc_c_q;
      ovf_d   = cnt_q > (G+1)'(2 ** (G - 1));
      acc_s_d = '0;
      acc_c_d = '0;
      cnt_d   = '0;
      state_d = OUT;
    end else if (out_ready) begin
      state_d = ACC;
    end
  end
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= ACC;
      acc_s_q <= '0;
      acc_c_q <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_s_q <= acc_s_d;
      acc_c_q <= acc_c_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      ovf_q   <= ovf_d;
    end
  end
endmodule
